// File: rtl/lab5_pkg.sv
// Shared widths and FSM encoding for the two-port RAM arbiter.
package lab5_pkg;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 6;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
endpackage

// File: rtl/lab5_ram_arbiter_if.sv
// Requester-side bus for the RAM arbiter: two request ports and the shared read-data return.
interface lab5_ram_arbiter_if;
    import lab5_pkg::*;

    // reqN is the valid. Once raised, the requester holds reqN, weN, addrN and wdataN
    // stable until it sees doneN. doneN is a one-cycle acknowledge, and rdata is valid
    // only in that cycle. The requester drops reqN at the edge that samples doneN.
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              done0;
    logic              done1;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  done0, done1, rdata
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output done0, done1, rdata
    );
endinterface

// File: rtl/lab5_rr_pick.sv
// Combinational two-way round-robin pick: a lone request always wins, a tie goes to ptr.
module lab5_rr_pick (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       grant,
    output logic       valid
);
    always_comb begin
        valid = |req;
        grant = 1'b0;
        if (req == 2'b11) begin
            grant = ptr;
        end else if (req[1]) begin
            grant = 1'b1;
        end
    end
endmodule

// File: rtl/lab5_ram_arbiter.sv
// Round-robin sequencer for a single-port 64x8 synchronous RAM shared by two requesters.
// Each access occupies IDLE -> ISSUE -> WAIT -> DONE, so one access completes every 4 cycles.
module lab5_ram_arbiter
    import lab5_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    lab5_ram_arbiter_if.slave   bus,
    output logic                busy,
    output logic [DATA_W-1:0]   ram_in,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic                ram_cs,
    output logic                ram_write,
    input  logic [DATA_W-1:0]   ram_out,
    output state_t              state
);
    logic              pick_grant;
    logic              pick_valid;
    logic              grant;
    logic              rr_ptr;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    lab5_rr_pick u_pick (
        .req   ({bus.req1, bus.req0}),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    always_comb begin
        sel_we    = pick_grant ? bus.we1    : bus.we0;
        sel_addr  = pick_grant ? bus.addr1  : bus.addr0;
        sel_wdata = pick_grant ? bus.wdata1 : bus.wdata0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            ram_cs    <= 1'b0;
            ram_write <= 1'b0;
            ram_addr  <= '0;
            ram_in    <= '0;
            bus.done0 <= 1'b0;
            bus.done1 <= 1'b0;
            bus.rdata <= '0;
            rr_ptr    <= 1'b0;
            grant     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        ram_cs    <= 1'b1;
                        ram_write <= sel_we;
                        ram_addr  <= sel_addr;
                        ram_in    <= sel_we ? sel_wdata : '0;
                        grant     <= pick_grant;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // The RAM samples cs/write at this edge; drop them so it stays idle afterwards.
                    ram_cs    <= 1'b0;
                    ram_write <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: begin
                    bus.rdata <= ram_out;
                    if (grant) begin
                        bus.done1 <= 1'b1;
                    end else begin
                        bus.done0 <= 1'b1;
                    end
                    // Favour the port that was just not served, so contention alternates.
                    rr_ptr <= ~grant;
                    state  <= DONE;
                end
                DONE: begin
                    bus.done0 <= 1'b0;
                    bus.done1 <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
